// File: rtl/axi_lite_s_regs.sv
// axi_lite_s_regs
// AXI4-Lite slave register file. Accepts single-beat writes (AW and W may
// arrive in any order) and single-beat reads, keeps NUM_REGS 32-bit registers
// with byte-strobe writes and exports them flat on regs_q together with a
// one-cycle wr_stb/wr_idx pulse for every committed in-range write.
//
// Build option: define AXIL_S_REGS_OOR_ERR_EN to answer out-of-range accesses
// with SLVERR (2'b10). Without it they are answered OKAY. In both builds an
// out-of-range write changes nothing and an out-of-range read returns zero.
module axi_lite_s_regs #(
   parameter int          NUM_REGS  = 8,
   parameter int          ADDR_W    = 32,
   parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [ADDR_W-1:0]        s_axi_awaddr,
   input  logic [2:0]               s_axi_awprot,
   input  logic                     s_axi_awvalid,
   output logic                     s_axi_awready,
   input  logic [31:0]              s_axi_wdata,
   input  logic [3:0]               s_axi_wstrb,
   input  logic                     s_axi_wvalid,
   output logic                     s_axi_wready,
   output logic [1:0]               s_axi_bresp,
   output logic                     s_axi_bvalid,
   input  logic                     s_axi_bready,
   input  logic [ADDR_W-1:0]        s_axi_araddr,
   input  logic [2:0]               s_axi_arprot,
   input  logic                     s_axi_arvalid,
   output logic                     s_axi_arready,
   output logic [31:0]              s_axi_rdata,
   output logic [1:0]               s_axi_rresp,
   output logic                     s_axi_rvalid,
   input  logic                     s_axi_rready,
   output logic [NUM_REGS*32-1:0]   regs_q,
   output logic                     wr_stb,
   output logic [7:0]               wr_idx
);

   localparam int IDX_W = ADDR_W - 2;

   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_S_REGS_OOR_ERR_EN
   localparam logic [1:0] RESP_OOR  = 2'b10;
`else
   localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

   typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   // Word index lies inside the register file.
   function automatic logic in_range_f(input logic [IDX_W-1:0] idx);
      return (64'(idx) < 64'(NUM_REGS));
   endfunction

   // Overlay the strobed bytes of new_val onto old_val.
   function automatic logic [31:0] strb_merge_f(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) begin
            res[8*b +: 8] = new_val[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_val[8*b +: 8];
         end
      end
      return res;
   endfunction

   // ---------------------------------------------------------------- state
   logic [31:0]      regs_r [NUM_REGS];

   w_state_t         w_state_r;
   w_state_t         w_state_nxt_s;
   logic             aw_held_r;
   logic             w_held_r;
   logic [IDX_W-1:0] aw_idx_r;
   logic [31:0]      wdata_r;
   logic [3:0]       wstrb_r;
   logic             bvalid_r;
   logic [1:0]       bresp_r;
   logic             wr_stb_r;
   logic [7:0]       wr_idx_r;

   logic             awready_s;
   logic             wready_s;
   logic             commit_s;
   logic             b_done_s;
   logic             w_in_range_s;

   r_state_t         r_state_r;
   r_state_t         r_state_nxt_s;
   logic             rvalid_r;
   logic [31:0]      rdata_r;
   logic [1:0]       rresp_r;

   logic             arready_s;
   logic             ar_hs_s;
   logic             r_done_s;
   logic [IDX_W-1:0] ar_idx_s;
   logic [31:0]      rd_data_s;

   // Protection bits and the byte offset within a word carry no meaning here.
   logic             unused_s;
   assign unused_s = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   assign w_in_range_s = in_range_f(aw_idx_r);
   assign ar_idx_s     = s_axi_araddr[ADDR_W-1:2];

   // ------------------------------------------------------------ write FSM
   // Write FSM state register.
   always_ff @(posedge aclk) begin
      if (areset) begin
         w_state_r <= W_IDLE;
      end else begin
         w_state_r <= w_state_nxt_s;
      end
   end

   // Write FSM next state: commit once both halves are held, wait for bready.
   always_comb begin
      w_state_nxt_s = w_state_r;
      case (w_state_r)
         W_IDLE: begin
            if (aw_held_r && w_held_r) begin
               w_state_nxt_s = W_RESP;
            end else begin
               w_state_nxt_s = W_IDLE;
            end
         end
         W_RESP: begin
            if (s_axi_bready) begin
               w_state_nxt_s = W_IDLE;
            end else begin
               w_state_nxt_s = W_RESP;
            end
         end
         default: w_state_nxt_s = W_IDLE;
      endcase
   end

   // Write FSM outputs: channel readies, commit and response-done strobes.
   always_comb begin
      awready_s = 1'b0;
      wready_s  = 1'b0;
      commit_s  = 1'b0;
      b_done_s  = 1'b0;
      case (w_state_r)
         W_IDLE: begin
            awready_s = !aw_held_r;
            wready_s  = !w_held_r;
            commit_s  = aw_held_r && w_held_r;
         end
         W_RESP: begin
            b_done_s  = s_axi_bready;
         end
         default: begin
            awready_s = 1'b0;
            wready_s  = 1'b0;
         end
      endcase
   end

   // Capture AW and W independently; both holding slots empty on commit.
   always_ff @(posedge aclk) begin
      if (areset) begin
         aw_held_r <= 1'b0;
         w_held_r  <= 1'b0;
         aw_idx_r  <= {IDX_W{1'b0}};
         wdata_r   <= 32'h0000_0000;
         wstrb_r   <= 4'h0;
      end else if (commit_s) begin
         aw_held_r <= 1'b0;
         w_held_r  <= 1'b0;
      end else begin
         if (awready_s && s_axi_awvalid) begin
            aw_held_r <= 1'b1;
            aw_idx_r  <= s_axi_awaddr[ADDR_W-1:2];
         end
         if (wready_s && s_axi_wvalid) begin
            w_held_r <= 1'b1;
            wdata_r  <= s_axi_wdata;
            wstrb_r  <= s_axi_wstrb;
         end
      end
   end

   // B channel and fabric write strobe, both produced on the commit edge.
   always_ff @(posedge aclk) begin
      if (areset) begin
         bvalid_r <= 1'b0;
         bresp_r  <= RESP_OKAY;
         wr_stb_r <= 1'b0;
         wr_idx_r <= 8'h00;
      end else begin
         wr_stb_r <= commit_s && w_in_range_s;
         if (commit_s) begin
            bvalid_r <= 1'b1;
            bresp_r  <= w_in_range_s ? RESP_OKAY : RESP_OOR;
            if (w_in_range_s) begin
               wr_idx_r <= 8'(aw_idx_r);
            end
         end else if (b_done_s) begin
            bvalid_r <= 1'b0;
         end
      end
   end

   // Register file: strobed byte update of the addressed register on commit.
   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= RESET_VAL;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_s && (aw_idx_r == IDX_W'(i))) begin
               regs_r[i] <= strb_merge_f(regs_r[i], wdata_r, wstrb_r);
            end
         end
      end
   end

   // ------------------------------------------------------------- read FSM
   // Read mux over current contents; out-of-range indices read as zero.
   always_comb begin
      rd_data_s = 32'h0000_0000;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ar_idx_s == IDX_W'(i)) begin
            rd_data_s = regs_r[i];
         end else begin
            rd_data_s = rd_data_s;
         end
      end
   end

   // Read FSM state register.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state_r <= R_IDLE;
      end else begin
         r_state_r <= r_state_nxt_s;
      end
   end

   // Read FSM next state: one outstanding read, held until rready.
   always_comb begin
      r_state_nxt_s = r_state_r;
      case (r_state_r)
         R_IDLE: begin
            if (s_axi_arvalid) begin
               r_state_nxt_s = R_DATA;
            end else begin
               r_state_nxt_s = R_IDLE;
            end
         end
         R_DATA: begin
            if (s_axi_rready) begin
               r_state_nxt_s = R_IDLE;
            end else begin
               r_state_nxt_s = R_DATA;
            end
         end
         default: r_state_nxt_s = R_IDLE;
      endcase
   end

   // Read FSM outputs: arready and handshake strobes.
   always_comb begin
      arready_s = 1'b0;
      ar_hs_s   = 1'b0;
      r_done_s  = 1'b0;
      case (r_state_r)
         R_IDLE: begin
            arready_s = 1'b1;
            ar_hs_s   = s_axi_arvalid;
         end
         R_DATA: begin
            r_done_s  = s_axi_rready;
         end
         default: begin
            arready_s = 1'b0;
         end
      endcase
   end

   // R channel registers; data sampled before any same-edge write lands.
   always_ff @(posedge aclk) begin
      if (areset) begin
         rvalid_r <= 1'b0;
         rdata_r  <= 32'h0000_0000;
         rresp_r  <= RESP_OKAY;
      end else if (ar_hs_s) begin
         rvalid_r <= 1'b1;
         rdata_r  <= rd_data_s;
         rresp_r  <= in_range_f(ar_idx_s) ? RESP_OKAY : RESP_OOR;
      end else if (r_done_s) begin
         rvalid_r <= 1'b0;
      end
   end

   // ---------------------------------------------------------------- ports
   assign s_axi_awready = awready_s;
   assign s_axi_wready  = wready_s;
   assign s_axi_bvalid  = bvalid_r;
   assign s_axi_bresp   = bresp_r;
   assign s_axi_arready = arready_s;
   assign s_axi_rvalid  = rvalid_r;
   assign s_axi_rdata   = rdata_r;
   assign s_axi_rresp   = rresp_r;
   assign wr_stb        = wr_stb_r;
   assign wr_idx        = wr_idx_r;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_q[32*g +: 32] = regs_r[g];
   end

endmodule

// File: tb/tb_axi_lite_s_regs.sv
// tb_axi_lite_s_regs
// Directed and randomized AXI-Lite traffic against axi_lite_s_regs, checked
// against a plain array model of the register file and the handshake timing.
module tb_axi_lite_s_regs;

   localparam int          NUM_REGS  = 8;
   localparam int          ADDR_W    = 32;
   localparam logic [31:0] RESET_VAL = 32'hA5A5_0F0F;
`ifdef AXIL_S_REGS_OOR_ERR_EN
   localparam logic [1:0]  EXP_OOR   = 2'b10;
`else
   localparam logic [1:0]  EXP_OOR   = 2'b00;
`endif

   logic                    aclk = 1'b0;
   logic                    areset;
   logic [ADDR_W-1:0]       s_axi_awaddr;
   logic [2:0]              s_axi_awprot;
   logic                    s_axi_awvalid;
   logic                    s_axi_awready;
   logic [31:0]             s_axi_wdata;
   logic [3:0]              s_axi_wstrb;
   logic                    s_axi_wvalid;
   logic                    s_axi_wready;
   logic [1:0]              s_axi_bresp;
   logic                    s_axi_bvalid;
   logic                    s_axi_bready;
   logic [ADDR_W-1:0]       s_axi_araddr;
   logic [2:0]              s_axi_arprot;
   logic                    s_axi_arvalid;
   logic                    s_axi_arready;
   logic [31:0]             s_axi_rdata;
   logic [1:0]              s_axi_rresp;
   logic                    s_axi_rvalid;
   logic                    s_axi_rready;
   logic [NUM_REGS*32-1:0]  regs_q;
   logic                    wr_stb;
   logic [7:0]              wr_idx;

   always #5 aclk = ~aclk;

   axi_lite_s_regs #(
      .NUM_REGS  (NUM_REGS),
      .ADDR_W    (ADDR_W),
      .RESET_VAL (RESET_VAL)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awprot  (s_axi_awprot),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arprot  (s_axi_arprot),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .regs_q        (regs_q),
      .wr_stb        (wr_stb),
      .wr_idx        (wr_idx)
   );

   int          n_vec     = 0;
   int          n_miscomp = 0;
   logic [31:0] model_regs [NUM_REGS];
   logic [7:0]  model_wr_idx;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscomp++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; afterwards outputs are settled and inputs may be changed.
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
      logic [31:0] mask;
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   function automatic int word_of(input logic [31:0] addr);
      return int'(addr >> 2);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_REGS; i++) model_regs[i] = RESET_VAL;
      model_wr_idx = 8'h00;
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NUM_REGS; i++) begin
         check_val(tag, 64'(regs_q[32*i +: 32]), 64'(model_regs[i]));
      end
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_awready"}, 64'(s_axi_awready), 64'd1);
      check_val({tag, "_wready"},  64'(s_axi_wready),  64'd1);
      check_val({tag, "_arready"}, 64'(s_axi_arready), 64'd1);
      check_val({tag, "_bvalid"},  64'(s_axi_bvalid),  64'd0);
      check_val({tag, "_rvalid"},  64'(s_axi_rvalid),  64'd0);
      check_val({tag, "_wr_stb"},  64'(wr_stb),        64'd0);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
      bit aw_done = 1'b0;
      bit w_done  = 1'b0;
      bit aw_hs;
      bit w_hs;
      int t = 0;
      int idx;
      bit inr;
      idx = word_of(addr);
      inr = (idx < NUM_REGS);
      while (!(aw_done && w_done) && t < 64) begin
         check_val("awready_open", 64'(s_axi_awready), 64'(!aw_done));
         check_val("wready_open",  64'(s_axi_wready),  64'(!w_done));
         check_val("bvalid_early", 64'(s_axi_bvalid),  64'd0);
         s_axi_awvalid = !aw_done && (t >= aw_dly);
         s_axi_awaddr  = s_axi_awvalid ? addr : $urandom();
         s_axi_wvalid  = !w_done && (t >= w_dly);
         s_axi_wdata   = s_axi_wvalid ? data : $urandom();
         s_axi_wstrb   = s_axi_wvalid ? strb : 4'($urandom());
         aw_hs = s_axi_awvalid && s_axi_awready;
         w_hs  = s_axi_wvalid && s_axi_wready;
         tick();
         if (aw_hs) aw_done = 1'b1;
         if (w_hs)  w_done  = 1'b1;
         t++;
      end
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      s_axi_bready  = 1'b0;
      if (!(aw_done && w_done)) begin
         check_val("write_hs_timeout", 64'd0, 64'd1);
         return;
      end
      // both halves captured, commit happens on the next edge
      check_val("bvalid_capture", 64'(s_axi_bvalid), 64'd0);
      check_val("wr_stb_capture", 64'(wr_stb),       64'd0);
      check_val("awready_held",   64'(s_axi_awready), 64'd0);
      check_val("wready_held",    64'(s_axi_wready),  64'd0);
      tick();
      if (inr) begin
         model_regs[idx] = byte_merge(model_regs[idx], data, strb);
         model_wr_idx    = 8'(idx);
      end
      check_val("bvalid_commit", 64'(s_axi_bvalid), 64'd1);
      check_val("bresp_commit",  64'(s_axi_bresp),  64'(inr ? 2'b00 : EXP_OOR));
      check_val("wr_stb_commit", 64'(wr_stb),       64'(inr));
      check_val("wr_idx_commit", 64'(wr_idx),       64'(model_wr_idx));
      check_regs("regs_commit");
      for (int k = 0; k < b_dly; k++) begin
         s_axi_awvalid = 1'b1;
         s_axi_awaddr  = $urandom();
         s_axi_wvalid  = 1'b1;
         s_axi_wdata   = $urandom();
         s_axi_wstrb   = 4'hF;
         tick();
         check_val("bvalid_hold",  64'(s_axi_bvalid),  64'd1);
         check_val("bresp_hold",   64'(s_axi_bresp),   64'(inr ? 2'b00 : EXP_OOR));
         check_val("awready_bwait", 64'(s_axi_awready), 64'd0);
         check_val("wready_bwait",  64'(s_axi_wready),  64'd0);
         check_val("wr_stb_bwait",  64'(wr_stb),        64'd0);
      end
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      s_axi_bready  = 1'b1;
      tick();
      s_axi_bready  = 1'b0;
      check_val("bvalid_done",  64'(s_axi_bvalid),  64'd0);
      check_val("awready_done", 64'(s_axi_awready), 64'd1);
      check_val("wready_done",  64'(s_axi_wready),  64'd1);
      check_val("wr_stb_done",  64'(wr_stb),        64'd0);
      check_regs("regs_done");
   endtask

   task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
      bit          done = 1'b0;
      int          t = 0;
      int          idx;
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
      idx   = word_of(addr);
      exp_d = (idx < NUM_REGS) ? model_regs[idx] : 32'h0000_0000;
      exp_r = (idx < NUM_REGS) ? 2'b00 : EXP_OOR;
      while (!done && t < 64) begin
         check_val("arready_open", 64'(s_axi_arready), 64'd1);
         check_val("rvalid_early", 64'(s_axi_rvalid),  64'd0);
         s_axi_arvalid = (t >= ar_dly);
         s_axi_araddr  = s_axi_arvalid ? addr : $urandom();
         done = s_axi_arvalid && s_axi_arready;
         tick();
         t++;
      end
      s_axi_arvalid = 1'b0;
      s_axi_rready  = 1'b0;
      if (!done) begin
         check_val("read_hs_timeout", 64'd0, 64'd1);
         return;
      end
      for (int k = 0; k <= r_dly; k++) begin
         check_val("rvalid",       64'(s_axi_rvalid),  64'd1);
         check_val("rdata",        64'(s_axi_rdata),   64'(exp_d));
         check_val("rresp",        64'(s_axi_rresp),   64'(exp_r));
         check_val("arready_busy", 64'(s_axi_arready), 64'd0);
         s_axi_rready = (k == r_dly);
         tick();
      end
      s_axi_rready = 1'b0;
      check_val("rvalid_done",  64'(s_axi_rvalid),  64'd0);
      check_val("arready_done", 64'(s_axi_arready), 64'd1);
   endtask

   initial begin
      logic [31:0] old_v;
      logic [31:0] addr;
      int          r;

      areset        = 1'b1;
      s_axi_awaddr  = 32'h0;
      s_axi_awprot  = 3'b000;
      s_axi_awvalid = 1'b0;
      s_axi_wdata   = 32'h0;
      s_axi_wstrb   = 4'h0;
      s_axi_wvalid  = 1'b0;
      s_axi_bready  = 1'b0;
      s_axi_araddr  = 32'h0;
      s_axi_arprot  = 3'b000;
      s_axi_arvalid = 1'b0;
      s_axi_rready  = 1'b0;
      model_reset();

      // reset state, during and after release
      tick();
      tick();
      check_idle("rst");
      check_val("rst_bresp", 64'(s_axi_bresp), 64'd0);
      check_val("rst_rresp", 64'(s_axi_rresp), 64'd0);
      check_val("rst_rdata", 64'(s_axi_rdata), 64'd0);
      check_val("rst_wr_idx", 64'(wr_idx), 64'd0);
      check_regs("rst_regs");
      areset = 1'b0;
      tick();
      check_idle("rel");

      // directed sequence
      do_read(32'h0000_0004, 0, 0);
      do_write(32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
      check_val("reg2_full", 64'(regs_q[95:64]), 64'h0000_0000_DEAD_BEEF);
      do_write(32'h0000_0008, 32'h0000_00AA, 4'h1, 3, 0, 0);
      check_val("reg2_merge", 64'(regs_q[95:64]), 64'h0000_0000_DEAD_BEAA);
      do_write(32'h0000_0014, 32'h1357_9BDF, 4'h6, 1, 0, 5);
      do_write(32'h0000_0018, 32'hCAFE_F00D, 4'h0, 0, 2, 1);
      do_write(32'(NUM_REGS * 4), 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
      do_read(32'(NUM_REGS * 4), 0, 0);
      do_read(32'h0000_0008, 1, 3);
      check_val("reg6_unchanged", 64'(regs_q[223:192]), 64'(RESET_VAL));

      // commit and AR handshake on the same edge: read sees the old value
      old_v         = model_regs[3];
      s_axi_awvalid = 1'b1;
      s_axi_awaddr  = 32'h0000_000C;
      s_axi_wvalid  = 1'b1;
      s_axi_wdata   = 32'h0F1E_2D3C;
      s_axi_wstrb   = 4'hF;
      tick();
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      s_axi_arvalid = 1'b1;
      s_axi_araddr  = 32'h0000_000C;
      tick();
      s_axi_arvalid = 1'b0;
      model_regs[3] = 32'h0F1E_2D3C;
      model_wr_idx  = 8'd3;
      check_val("race_rvalid", 64'(s_axi_rvalid), 64'd1);
      check_val("race_rdata",  64'(s_axi_rdata),  64'(old_v));
      check_val("race_bvalid", 64'(s_axi_bvalid), 64'd1);
      check_val("race_wr_idx", 64'(wr_idx),       64'd3);
      check_regs("race_regs");
      s_axi_bready = 1'b1;
      s_axi_rready = 1'b1;
      tick();
      s_axi_bready = 1'b0;
      s_axi_rready = 1'b0;
      check_idle("race_done");

      // reset with AW held and a read response pending
      s_axi_arvalid = 1'b1;
      s_axi_araddr  = 32'h0000_0004;
      tick();
      s_axi_arvalid = 1'b0;
      s_axi_awvalid = 1'b1;
      s_axi_awaddr  = 32'h0000_0008;
      tick();
      s_axi_awvalid = 1'b0;
      check_val("pre_rst_rvalid",  64'(s_axi_rvalid),  64'd1);
      check_val("pre_rst_awready", 64'(s_axi_awready), 64'd0);
      areset = 1'b1;
      tick();
      areset = 1'b0;
      model_reset();
      check_idle("mid_rst");
      check_val("mid_rst_rdata", 64'(s_axi_rdata), 64'd0);
      check_regs("mid_rst_regs");
      // a lone W after reset must not pair with the discarded AW
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = 32'h1111_2222;
      s_axi_wstrb  = 4'hF;
      tick();
      s_axi_wvalid = 1'b0;
      tick();
      tick();
      check_val("lone_w_bvalid",  64'(s_axi_bvalid),  64'd0);
      check_val("lone_w_awready", 64'(s_axi_awready), 64'd1);
      check_val("lone_w_wready",  64'(s_axi_wready),  64'd0);
      check_regs("lone_w_regs");
      areset = 1'b1;
      tick();
      areset = 1'b0;
      tick();
      check_idle("rst2");

      // randomized traffic
      for (int it = 0; it < 120; it++) begin
         r = int'($urandom_range(0, 9));
         if (r < 8) begin
            addr = 32'($urandom_range(0, NUM_REGS - 1)) << 2;
         end else if (r == 8) begin
            addr = 32'($urandom_range(NUM_REGS, NUM_REGS + 3)) << 2;
         end else begin
            addr = 32'hFFFF_FFF0;
         end
         addr = addr | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            do_write(addr, $urandom(), 4'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)));
         end else begin
            do_read(addr, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
         end
      end
      check_regs("final_regs");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
      $finish;
   end

endmodule

// File: doc/axi_lite_s_regs.md
# axi_lite_s_regs

AXI4-Lite slave register file: the downstream endpoint for the team's AXI-Lite master. It accepts single-beat write and read transactions, stores NUM_REGS 32-bit registers with byte-strobe writes, and returns B/R responses. Register contents are exported flat to fabric logic, with a one-cycle write strobe per committed write.

## Interface
- NUM_REGS, 8, number of 32-bit registers (1..256).
- ADDR_W, 32, width of awaddr/araddr.
- RESET_VAL, 32'h0, reset value of every register.

- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axi_awaddr  in  ADDR_W  write address (byte address).
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables; bit i gates wdata[8i+7:8i].
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake.
- s_axi_bresp  out  2  00 OKAY, 10 SLVERR.
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake.
- s_axi_araddr  in  ADDR_W  read address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  00 OKAY, 10 SLVERR.
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake.
- regs_q  out  NUM_REGS*32  register i at bits [32i+31:32i].
- wr_stb  out  1  one-cycle pulse on each committed in-range write.
- wr_idx  out  8  index of register written; valid with wr_stb.

## Operation
- Index = addr[ADDR_W-1:2]; addr[1:0] ignored. In range iff index < NUM_REGS.
- Write path, states W_IDLE, W_RESP. In W_IDLE, AW and W are captured independently into holding registers (aw_held, w_held flags); either may arrive first or both in the same cycle.
- awready = W_IDLE && !aw_held; wready = W_IDLE && !w_held.
- Commit: on the edge after both are held, in-range register updated per wstrb (unstrobed bytes unchanged), wr_stb=1, wr_idx=index, bvalid=1, bresp set, state to W_RESP, flags cleared.
- W_RESP: bvalid and bresp stable until bready; on bvalid&&bready, back to W_IDLE. No AW/W accepted in W_RESP.
- wstrb=0 in range: register unchanged, wr_stb still pulses, bresp OKAY.
- Read path, states R_IDLE, R_DATA. arready = R_IDLE. On arvalid&&arready, rdata/rresp registered from current register contents, rvalid=1, state R_DATA. rdata/rresp stable until rready; then R_IDLE.
- Simultaneous commit and AR handshake on same register in same cycle: read returns pre-write value.
- Read and write paths independent; one outstanding transaction per path.

## Timing
- Reset values: awready=1, wready=1, arready=1, bvalid=0, bresp=00, rvalid=0, rresp=00, rdata=0, wr_stb=0, wr_idx=0, all registers RESET_VAL, holding flags clear.
- Write latency: AW and W same cycle N -> bvalid high at cycle N+2 (capture edge N, commit edge N+1); regs_q reflects new value from N+2.
- Read latency: AR handshake at cycle N -> rvalid high at cycle N+1.
- Back-to-back: ready re-asserts the cycle after the B/R handshake; max throughput one write per 3 cycles, one read per 2 cycles.
- Reset mid-transaction: held AW/W, pending B and R discarded; outputs to reset values the next cycle; registers revert to RESET_VAL.

## Configuration
- AXIL_S_REGS_OOR_ERR_EN defined: out-of-range write drops data, bresp=10; out-of-range read returns rdata=0, rresp=10; wr_stb not pulsed.
- Undefined: out-of-range write dropped with bresp=00; read returns rdata=0, rresp=00; wr_stb not pulsed. In-range behaviour identical in both builds.

## Test plan
- Reset then read addr 0x4 -> rvalid one cycle after AR handshake, rdata=RESET_VAL, rresp=00; all readies 1 during reset release.
- AW addr 0x8 and W data 0xDEADBEEF strb 4'hF same cycle, bready=1 -> bvalid two cycles later, bresp=00, wr_stb with wr_idx=2, regs_q[95:64]=0xDEADBEEF.
- W (0x000000AA, strb 4'h1) three cycles before AW addr 0x8 over prior 0xDEADBEEF -> reg2=0xDEADBEAA; awready stays 1, wready 0 while W held.
- bready held 0 for 5 cycles -> bvalid/bresp stable, awready/wready 0 throughout; new AW waits until after B handshake.
- Write addr NUM_REGS*4 (0x20 at default) and read same -> with AXIL_S_REGS_OOR_ERR_EN bresp=rresp=10, else 00; rdata=0, no register changes, no wr_stb.
- areset asserted while AW held and rvalid pending with rready=0 -> next cycle bvalid=rvalid=0, all readies 1, registers RESET_VAL.
